// File: rtl/llac_filt_pkg.sv
// Shared definitions for the per-channel audio filter chain.
//
// Contents:
//   AUDIO_DATA_W - default sample width for the I2S audio path
//   sample_t     - signed audio sample at the default width
//   acc_width()  - accumulator width for a 2**log2_n sample running sum
package llac_filt_pkg;

    localparam int AUDIO_DATA_W = 24;

    typedef logic signed [AUDIO_DATA_W-1:0] sample_t;

    // A sum of 2**log2_n signed data_w-bit values needs log2_n extra bits,
    // so the running sum cannot overflow.
    function automatic int acc_width(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

endpackage

// File: rtl/avg_fir_delay_line.sv
// Circular delay line with a write pointer, a fill counter and a
// read-old-on-write port. Each write stores wr_data and, in the same cycle,
// registers the sample written exactly N writes earlier. Until N samples have
// been written, the old sample reads as zero. Comb and CIC stages can reuse it.
//
// Ports:
//   clk      - clock
//   rst      - asynchronous active-high reset (pointer, fill count, full flag)
//   clr      - synchronous flush; history is treated as empty afterwards
//   wr_en    - write a new sample and capture the oldest one
//   wr_data  - sample to write
//   old_data - sample from N writes ago (zero during fill), valid after wr_en
module avg_fir_delay_line #(
    parameter int DATA_W = 24,
    parameter int LOG2_N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] old_data
);

    localparam int N = 1 << LOG2_N;
    localparam logic [LOG2_N:0] FULL_CNT = {1'b1, {LOG2_N{1'b0}}};

    logic [LOG2_N-1:0] wr_ptr;
    logic [LOG2_N:0]   fill_cnt;
    logic              full;
    logic              full_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mem [N];

    assign full = (fill_cnt == FULL_CNT);

    // wr_ptr is exactly LOG2_N bits wide, so the increment wraps modulo N.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            fill_cnt <= '0;
            full_q   <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            fill_cnt <= '0;
            full_q   <= 1'b0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            full_q <= full;
            if (!full) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    // Read-before-write at one address with a registered read and no reset.
    // This maps onto a simple dual-port RAM when the line is long, and onto
    // a small flop array when it is short.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            rd_q        <= mem[wr_ptr];
        end
    end

    // During fill, the slot being read holds stale data, so it is masked
    // to zero. This gives the ramp against implicit zeros.
    assign old_data = full_q ? rd_q : '0;

endmodule

// File: rtl/avg_fir.sv
// Boxcar moving-average filter: y[n] = floor(sum(x[n-N+1..n]) / N), N = 2**LOG2_N.
// The filter keeps a running sum: each new sample is added and the sample
// from N accepts ago is subtracted. The circular delay line supplies that
// old sample. The filter is a two-stage pipeline with valid/ready on both
// sides, and all stages stall together under output backpressure.
//
// Ports:
//   i_clk    - sample-domain clock
//   i_rst    - asynchronous active-high reset
//   i_clr    - synchronous flush of history and pipeline (wins over i_valid)
//   i_valid  - input sample valid
//   o_ready  - input accepted this cycle when i_valid is high
//   i_sample - signed input sample
//   o_valid  - output sample valid
//   i_ready  - downstream accepts o_sample
//   o_sample - signed averaged sample
module avg_fir
    import llac_filt_pkg::*;
#(
    parameter int DATA_W = AUDIO_DATA_W,
    parameter int LOG2_N = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic signed [DATA_W-1:0] i_sample,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic signed [DATA_W-1:0] o_sample
);

    localparam int ACC_W = acc_width(DATA_W, LOG2_N);

    logic                     adv;
    logic                     accept;
    logic                     s1_valid;
    logic signed [DATA_W-1:0] new_q;
    logic        [DATA_W-1:0] old_raw;
    logic signed [DATA_W-1:0] old_q;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  new_ext;
    logic signed [ACC_W-1:0]  old_ext;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  acc_shr;

    // The whole pipeline moves when the output register is empty or is
    // being drained. o_ready therefore depends combinationally on i_ready.
    assign adv     = !o_valid || i_ready;
    assign o_ready = adv && !i_clr;
    assign accept  = i_valid && o_ready;

    avg_fir_delay_line #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_delay_line (
        .clk      (i_clk),
        .rst      (i_rst),
        .clr      (i_clr),
        .wr_en    (accept),
        .wr_data  (i_sample),
        .old_data (old_raw)
    );

    assign old_q = old_raw;

    // Stage 1: register the newest sample. Its matching oldest sample is
    // registered inside the delay line on the same accept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            new_q    <= '0;
        end else if (i_clr) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            new_q    <= i_sample;
        end else if (adv) begin
            s1_valid <= 1'b0;
        end
    end

    assign new_ext  = {{LOG2_N{new_q[DATA_W-1]}}, new_q};
    assign old_ext  = {{LOG2_N{old_q[DATA_W-1]}}, old_q};
    assign acc_next = acc + new_ext - old_ext;
    // The arithmetic shift floors toward minus infinity. The sum of N
    // samples divided by N always fits back into DATA_W bits.
    assign acc_shr  = acc_next >>> LOG2_N;

    // Stage 2: update the running sum and the output register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc      <= '0;
            o_sample <= '0;
            o_valid  <= 1'b0;
        end else if (i_clr) begin
            acc     <= '0;
            o_valid <= 1'b0;
        end else if (adv) begin
            if (s1_valid) begin
                acc      <= acc_next;
                o_sample <= acc_shr[DATA_W-1:0];
                o_valid  <= 1'b1;
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_avg_fir.sv
module tb_avg_fir;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_clr;
    logic               i_valid;
    logic               o_ready;
    logic signed [15:0] i_sample;
    logic               o_valid;
    logic               i_ready;
    logic signed [15:0] o_sample;

    int total = 0;
    int bad   = 0;
    int base;

    logic signed [15:0] outq [$];

    always #5 i_clk = ~i_clk;

    avg_fir #(
        .DATA_W (16),
        .LOG2_N (2)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (i_clr),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_sample (i_sample),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_sample (o_sample)
    );

    // Record every output transfer (the values are stable at the falling edge).
    always @(negedge i_clk) begin
        if (!i_rst && !i_clr && o_valid && i_ready) begin
            outq.push_back(o_sample);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Present one sample and hold it until it is accepted (bounded wait).
    task automatic send(input int v);
        logic took;
        took     = 1'b0;
        i_valid  = 1'b1;
        i_sample = 16'(v);
        for (int k = 0; k < 32 && !took; k++) begin
            #1;
            took = o_ready;
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        if (!took) begin
            total++;
            bad++;
            $error("FAIL send_timeout: got no accept want accept of %0d", v);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic flush();
        i_clr = 1'b1;
        @(posedge i_clk);
        #1;
        i_clr = 1'b0;
    endtask

    task automatic check_stream(input string tag, input int first, input int exp [8], input int n);
        int obs;
        chk({tag, "_count"}, outq.size() - first, n);
        for (int i = 0; i < n; i++) begin
            obs = (first + i < outq.size()) ? int'(outq[first + i]) : -999999;
            chk($sformatf("%s_%0d", tag, i), obs, exp[i]);
        end
    endtask

    initial begin
        i_rst    = 1'b0;
        i_clr    = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b1;
        i_sample = '0;
        #1 i_rst = 1'b1;
        #11;
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_o_sample", int'(o_sample), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        chk("rst_o_ready", int'(o_ready), 1);

        // Step response, including two-cycle latency of the first sample.
        base     = outq.size();
        i_valid  = 1'b1;
        i_sample = 16'sd1000;
        @(posedge i_clk);
        #1;
        chk("lat_t1_valid", int'(o_valid), 0);
        @(posedge i_clk);
        #1;
        chk("lat_t2_valid", int'(o_valid), 1);
        chk("lat_t2_data", int'(o_sample), 250);
        i_valid = 1'b0;
        repeat (4) send(1000);
        idle(4);
        check_stream("step", base, '{250, 500, 750, 1000, 1000, 1000, 0, 0}, 6);

        // Impulse: the oldest sample is subtracted after the pointer wraps.
        flush();
        base = outq.size();
        send(4000);
        repeat (7) send(0);
        idle(4);
        check_stream("impulse", base, '{1000, 1000, 1000, 1000, 0, 0, 0, 0}, 8);

        // Negative values round by floor.
        flush();
        base = outq.size();
        repeat (5) send(-1);
        idle(4);
        check_stream("neg_const", base, '{-1, -1, -1, -1, -1, 0, 0, 0}, 5);

        flush();
        base = outq.size();
        send(-3);
        repeat (3) send(0);
        idle(4);
        check_stream("neg_floor", base, '{-1, -1, -1, -1, 0, 0, 0, 0}, 4);

        // Backpressure: the output holds and no sample is lost.
        flush();
        base = outq.size();
        send(100);
        send(200);
        chk("bp_first_valid", int'(o_valid), 1);
        chk("bp_first_data", int'(o_sample), 25);
        i_ready  = 1'b0;
        i_valid  = 1'b1;
        i_sample = 16'sd300;
        #1;
        chk("bp_ready_drop", int'(o_ready), 0);
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk);
            #1;
            chk($sformatf("bp_hold_data_%0d", c), int'(o_sample), 25);
            chk($sformatf("bp_hold_valid_%0d", c), int'(o_valid), 1);
        end
        chk("bp_ready_held_low", int'(o_ready), 0);
        i_ready = 1'b1;
        send(300);
        send(400);
        send(500);
        idle(4);
        check_stream("bp", base, '{25, 75, 150, 250, 350, 0, 0, 0}, 5);

        // Clear wins over a simultaneous valid and zeroes the history.
        flush();
        repeat (4) send(800);
        i_clr    = 1'b1;
        i_valid  = 1'b1;
        i_sample = 16'sd999;
        #1;
        chk("clr_ready_low", int'(o_ready), 0);
        @(posedge i_clk);
        #1;
        i_clr   = 1'b0;
        i_valid = 1'b0;
        chk("clr_valid_drop", int'(o_valid), 0);
        idle(3);
        chk("clr_no_output", int'(o_valid), 0);
        base = outq.size();
        send(400);
        idle(4);
        check_stream("clr_after", base, '{100, 0, 0, 0, 0, 0, 0, 0}, 1);

        // Asynchronous reset applied mid-stream, between clock edges.
        flush();
        repeat (3) send(1000);
        chk("arst_pre_valid", int'(o_valid), 1);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_valid", int'(o_valid), 0);
        chk("arst_data", int'(o_sample), 0);
        chk("arst_ready", int'(o_ready), 1);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        base = outq.size();
        repeat (4) send(1000);
        idle(4);
        check_stream("arst_after", base, '{250, 500, 750, 1000, 0, 0, 0, 0}, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avg_fir.md
Name: avg_fir

Overview:
Boxcar moving-average (N-tap FIR) low-pass filter. It is the finite-memory counterpart of the recursive averaging IIR and uses the same audio sample stream. It computes y[n] = floor((x[n] + ... + x[n-N+1]) / N) with a circular delay line and a recursive running sum (add newest, subtract oldest). It sits in the per-channel filter chain behind the I2S deserialiser, with valid/ready streaming on both sides.

Parameters:
DATA_W, 24, signed sample width (two's complement).
LOG2_N, 4, log2 of tap count; N = 2**LOG2_N. Legal range 1..10.

Ports:
i_clk  in  1  sample-domain clock.
i_rst  in  1  asynchronous, active-high reset.
i_clr  in  1  synchronous flush of filter history and pipeline.
i_valid  in  1  input sample valid.
o_ready  out  1  block accepts i_sample this cycle.
i_sample  in  DATA_W  signed input sample.
o_valid  out  1  output sample valid.
i_ready  in  1  downstream accepts o_sample.
o_sample  out  DATA_W  signed averaged sample.

Behaviour:
- Reset (async on i_rst rise): o_valid=0, o_sample=0, wr_ptr=0, fill_cnt=0, acc=0, s1_valid=0. o_ready is 1 after reset. Delay-line contents are not reset.
- adv = !o_valid || i_ready. o_ready = adv && !i_clr. Input is accepted when i_valid && o_ready.
- Stage 1, on accept:
  - buf[wr_ptr] <= i_sample.
  - old_q <= (fill_cnt==N) ? buf[wr_ptr] : 0. The read happens before the write, so it returns the sample from exactly N accepts ago.
  - new_q <= i_sample; wr_ptr <= wr_ptr+1, wrapping modulo N.
  - fill_cnt increments and saturates at N.
  - s1_valid <= 1.
- Stage 1, when adv is high and there is no accept: s1_valid <= 0. When adv is low, stage 1 holds.
- Stage 2, when adv && s1_valid:
  - acc <= acc + new_q - old_q.
  - o_sample <= (acc + new_q - old_q) >>> LOG2_N (arithmetic shift, floor rounding).
  - o_valid <= 1.
- Stage 2, when adv && !s1_valid: o_valid <= 0.
- Latency: accept at cycle t gives o_valid at t+2 if there is no backpressure. Throughput is 1 sample per cycle.
- Arithmetic: acc is signed, width DATA_W+LOG2_N, and never overflows by construction. The output is the acc slice after the shift and always fits DATA_W. No saturation logic is needed.
- Fill phase: the first N-1 outputs average against implicit zeros, giving a ramp.
- Backpressure: while o_valid && !i_ready, all state holds and o_sample stays stable. o_ready=0 in this case, which is a combinational path from i_ready.
- i_clr: in the same cycle it clears wr_ptr, fill_cnt, acc, s1_valid and o_valid. Any in-flight sample is dropped. If i_clr and i_valid are both high, clear wins and the sample is not accepted.
- Reset asserted mid-stream: identical to the power-on reset values. No partial output is emitted.
- Delay line: inferred as simple dual-port RAM with a registered read (read-before-write at the same address) when N>=32, otherwise flops.

Decomposition:
- Shared package llac_filt_pkg holds:
  - typedef sample_t (logic signed [DATA_W-1:0]);
  - a function acc_width(DATA_W, LOG2_N);
  - a localparam default for audio DATA_W=24.
- Natural sub-module: avg_fir_delay_line. It is a circular buffer with write pointer, fill counter and read-old-on-write port, reusable by later comb/CIC stages.
- Top level keeps the handshake, accumulator and output register.

Test Plan:
- All tests use DATA_W=16, LOG2_N=2 (N=4).
- Step: reset, then stream 1000 x6 with i_ready=1 -> o_sample 250,500,750,1000,1000,1000; first o_valid 2 cycles after first accept.
- Impulse/wrap: 4000 then 0 x7 -> 1000,1000,1000,1000,0,0,0,0. Checks the oldest sample is subtracted after wr_ptr wraps.
- Negative floor: constant -1 x5 -> -1 on every output; input -3,0,0,0 -> -1,-1,-1,-1 (floor of -0.75).
- Backpressure: stream 100,200,300,400,500; hold i_ready=0 for 5 cycles after the first o_valid -> o_sample holds 25, o_ready drops within 1 cycle, no sample lost. Release gives 75,150,250,350.
- Clear: after 4 samples of 800, pulse i_clr with i_valid=1 -> that sample is not accepted, o_valid drops next cycle. The next input 400 yields 100 (history zeroed).
- Async reset: assert i_rst mid-stream, asynchronously between clock edges -> o_valid=0, o_sample=0 immediately. After release, 1000 x4 yields 250,500,750,1000.
